// File: rtl/rx_frame_receiver_param.sv
// Serial frame receiver: preamble/SFD hunt, MSB-first header+payload, inline CRC-8,
// destination filtering with optional broadcast, length-range check, done strobe.
module rx_frame_receiver_param #(
  parameter int unsigned     ID_W      = 2,
  parameter int unsigned     LEN_W     = 4,
  parameter int unsigned     MAX_BYTES = 16,
  parameter int unsigned     PRE_W     = 16,
  parameter logic [PRE_W-1:0] PREAMBLE = PRE_W'(16'hAAAA),
  parameter logic [7:0]      SFD       = 8'hAB,
  parameter logic [7:0]      CRC_POLY  = 8'h07,
  parameter logic [ID_W-1:0] MY_ID     = '0,
  parameter bit              BCAST_EN  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_line,
  output logic [ID_W-1:0]        dest_id,
  output logic [ID_W-1:0]        src_id,
  output logic [LEN_W-1:0]       length,
  output logic [8*MAX_BYTES-1:0] payload,
  output logic                   frame_valid,
  output logic                   crc_error,
  output logic                   len_error,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int unsigned HDR_W   = 2*ID_W + LEN_W;
  localparam int unsigned PAY_W   = 8*MAX_BYTES;
  localparam int unsigned PCNT_W  = $clog2(PAY_W + 1);
  localparam int unsigned HCNT_W  = $clog2(HDR_W + 1);
  localparam int unsigned CNT_W   = (PCNT_W > HCNT_W) ? PCNT_W : HCNT_W;

  typedef enum logic [2:0] {
    S_WAIT_PRE,
    S_WAIT_SFD,
    S_HEADER,
    S_PAYLOAD,
    S_RX_CRC
  } state_t;

  state_t             state, state_n;
  logic [PRE_W-1:0]   pre_sr, pre_sr_n, pre_shift;
  logic [7:0]         sfd_sr, sfd_sr_n, sfd_shift;
  logic [HDR_W-1:0]   hdr_sr, hdr_sr_n, hdr_shift;
  logic [7:0]         crc_rx, crc_rx_n, crc_rx_shift;
  logic [7:0]         crc, crc_n, crc_upd;
  logic [CNT_W-1:0]   cnt, cnt_n, pay_last;
  logic [ID_W-1:0]    dest_n, src_n, hdr_dest, hdr_src;
  logic [LEN_W-1:0]   length_n, hdr_len;
  logic [PAY_W-1:0]   payload_n;
  logic               frame_valid_n, crc_error_n, len_error_n, frame_done_n, busy_n;
  logic               len_too_big, addr_ok;

  // Shifted-in candidates and decoded header fields for the current line bit
  assign pre_shift    = {pre_sr[PRE_W-2:0], rx_line};
  assign sfd_shift    = {sfd_sr[6:0], rx_line};
  assign hdr_shift    = {hdr_sr[HDR_W-2:0], rx_line};
  assign crc_rx_shift = {crc_rx[6:0], rx_line};
  assign hdr_dest     = hdr_shift[HDR_W-1 -: ID_W];
  assign hdr_src      = hdr_shift[LEN_W +: ID_W];
  assign hdr_len      = hdr_shift[LEN_W-1:0];
  assign len_too_big  = (32'(hdr_len) + 32'd1) > MAX_BYTES;
  assign addr_ok      = (hdr_dest == MY_ID) || (BCAST_EN && (hdr_dest == '1));
  assign pay_last     = CNT_W'((32'(length) + 32'd1) * 32'd8 - 32'd1);
  assign crc_upd      = {crc[6:0], 1'b0} ^ ((crc[7] ^ rx_line) ? CRC_POLY : 8'h00);

  // Registers: FSM state, hunt/deserialise datapath and held outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_WAIT_PRE;
      pre_sr      <= '0;
      sfd_sr      <= '0;
      hdr_sr      <= '0;
      crc_rx      <= '0;
      crc         <= '0;
      cnt         <= '0;
      dest_id     <= '0;
      src_id      <= '0;
      length      <= '0;
      payload     <= '0;
      frame_valid <= 1'b0;
      crc_error   <= 1'b0;
      len_error   <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      pre_sr      <= pre_sr_n;
      sfd_sr      <= sfd_sr_n;
      hdr_sr      <= hdr_sr_n;
      crc_rx      <= crc_rx_n;
      crc         <= crc_n;
      cnt         <= cnt_n;
      dest_id     <= dest_n;
      src_id      <= src_n;
      length      <= length_n;
      payload     <= payload_n;
      frame_valid <= frame_valid_n;
      crc_error   <= crc_error_n;
      len_error   <= len_error_n;
      frame_done  <= frame_done_n;
      busy        <= busy_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n       = state;
    pre_sr_n      = pre_sr;
    sfd_sr_n      = sfd_sr;
    hdr_sr_n      = hdr_sr;
    crc_rx_n      = crc_rx;
    crc_n         = crc;
    cnt_n         = cnt;
    dest_n        = dest_id;
    src_n         = src_id;
    length_n      = length;
    payload_n     = payload;
    frame_valid_n = frame_valid;
    crc_error_n   = crc_error;
    len_error_n   = len_error;
    frame_done_n  = 1'b0;

    case (state)
      S_WAIT_PRE: begin
        crc_n    = '0;
        pre_sr_n = pre_shift;
        if (pre_shift == PREAMBLE) state_n = S_WAIT_SFD;
      end
      S_WAIT_SFD: begin
        crc_n    = '0;
        sfd_sr_n = sfd_shift;
        if (sfd_shift == SFD) begin
          state_n       = S_HEADER;
          cnt_n         = '0;
          hdr_sr_n      = '0;
          frame_valid_n = 1'b0;
          crc_error_n   = 1'b0;
          len_error_n   = 1'b0;
        end
      end
      S_HEADER: begin
        // Hunt registers are cleared here so a later hunt starts from fresh bits
        pre_sr_n = '0;
        sfd_sr_n = '0;
        hdr_sr_n = hdr_shift;
        crc_n    = crc_upd;
        cnt_n    = cnt + CNT_W'(1);
        if (cnt == CNT_W'(HDR_W - 1)) begin
          cnt_n   = '0;
          state_n = S_WAIT_PRE;
          if (len_too_big) begin
            len_error_n  = 1'b1;
            frame_done_n = 1'b1;
          end else if (addr_ok) begin
            dest_n    = hdr_dest;
            src_n     = hdr_src;
            length_n  = hdr_len;
            payload_n = '0;
            state_n   = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        payload_n = {payload[PAY_W-2:0], rx_line};
        crc_n     = crc_upd;
        cnt_n     = cnt + CNT_W'(1);
        if (cnt == pay_last) begin
          cnt_n    = '0;
          crc_rx_n = '0;
          state_n  = S_RX_CRC;
        end
      end
      S_RX_CRC: begin
        crc_rx_n = crc_rx_shift;
        cnt_n    = cnt + CNT_W'(1);
        if (cnt == CNT_W'(7)) begin
          cnt_n        = '0;
          frame_done_n = 1'b1;
          state_n      = S_WAIT_PRE;
          if (crc_rx_shift == crc) frame_valid_n = 1'b1;
          else                     crc_error_n   = 1'b1;
        end
      end
      default: state_n = S_WAIT_PRE;
    endcase

    busy_n = (state_n == S_HEADER) || (state_n == S_PAYLOAD) || (state_n == S_RX_CRC);
  end

endmodule

// File: tb/tb_rx_frame_receiver_param.sv
// Bench for rx_frame_receiver_param: default instance plus a LEN_W=5 instance.
module tb_rx_frame_receiver_param;

  logic clk = 1'b0;
  logic rst;
  logic rx0, rx1;

  logic [1:0]   d0_dest, d0_src, d1_dest, d1_src;
  logic [3:0]   d0_len;
  logic [4:0]   d1_len;
  logic [127:0] d0_pay, d1_pay;
  logic d0_fv, d0_ce, d0_le, d0_fd, d0_busy;
  logic d1_fv, d1_ce, d1_le, d1_fd, d1_busy;

  typedef struct packed {
    logic         fv;
    logic         ce;
    logic         le;
    logic [1:0]   dest;
    logic [1:0]   src;
    logic [4:0]   len;
    logic [127:0] pay;
  } exp_t;

  exp_t q0[$], q1[$];
  exp_t m0, m1, obs0, obs1, e0, e1;
  int tests = 0, fails = 0;
  int pushed0 = 0, pushed1 = 0, seen0 = 0, seen1 = 0;

  rx_frame_receiver_param u0 (
    .clk(clk), .rst(rst), .rx_line(rx0),
    .dest_id(d0_dest), .src_id(d0_src), .length(d0_len), .payload(d0_pay),
    .frame_valid(d0_fv), .crc_error(d0_ce), .len_error(d0_le),
    .frame_done(d0_fd), .busy(d0_busy)
  );

  rx_frame_receiver_param #(.LEN_W(5)) u1 (
    .clk(clk), .rst(rst), .rx_line(rx1),
    .dest_id(d1_dest), .src_id(d1_src), .length(d1_len), .payload(d1_pay),
    .frame_valid(d1_fv), .crc_error(d1_ce), .len_error(d1_le),
    .frame_done(d1_fd), .busy(d1_busy)
  );

  always #5 clk = ~clk;

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chke(input string tag, input exp_t obs, input exp_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  // Scoreboard pop for the default instance on every frame_done
  always @(negedge clk) begin
    if (!rst && d0_fd === 1'b1) begin
      seen0++;
      obs0.fv = d0_fv; obs0.ce = d0_ce; obs0.le = d0_le;
      obs0.dest = d0_dest; obs0.src = d0_src; obs0.len = {1'b0, d0_len}; obs0.pay = d0_pay;
      if (q0.size() == 0) chkv("u0 unexpected frame_done", 32'(d0_fd), 32'd0);
      else begin
        e0 = q0.pop_front();
        chke("u0 frame result", obs0, e0);
      end
    end
  end

  // Scoreboard pop for the LEN_W=5 instance
  always @(negedge clk) begin
    if (!rst && d1_fd === 1'b1) begin
      seen1++;
      obs1.fv = d1_fv; obs1.ce = d1_ce; obs1.le = d1_le;
      obs1.dest = d1_dest; obs1.src = d1_src; obs1.len = d1_len; obs1.pay = d1_pay;
      if (q1.size() == 0) chkv("u1 unexpected frame_done", 32'(d1_fd), 32'd0);
      else begin
        e1 = q1.pop_front();
        chke("u1 frame result", obs1, e1);
      end
    end
  end

  task automatic idle(input int n);
    rx0 = 1'b0; rx1 = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Build a frame, push its expected result, and shift it onto one line
  task automatic send_frame(input int inst, input logic [1:0] dest, input logic [1:0] src,
                            input logic [4:0] len, input logic [7:0] seed, input bit flip,
                            input bit hdr_only, input int abort_at);
    logic bq[$];
    logic [7:0] c = 8'h00;
    logic [7:0] bv;
    logic [15:0] pre = 16'hAAAA;
    logic [7:0] sfd = 8'hAB;
    logic [8:0] hv;
    int hw;
    int nb;
    exp_t e;
    bit lerr, acc;
    e = (inst == 0) ? m0 : m1;
    hw = (inst == 0) ? 8 : 9;
    hv = (inst == 0) ? {1'b0, dest, src, len[3:0]} : {dest, src, len};
    nb = (inst == 0) ? int'(len[3:0]) + 1 : int'(len) + 1;
    lerr = nb > 16;
    acc = (dest == 2'd0) || (dest == 2'd3);
    for (int i = 15; i >= 0; i--) bq.push_back(pre[i]);
    for (int i = 7; i >= 0; i--) bq.push_back(sfd[i]);
    for (int i = hw - 1; i >= 0; i--) begin bq.push_back(hv[i]); c = crc_step(c, hv[i]); end
    e.fv = 1'b0; e.ce = 1'b0; e.le = 1'b0;
    if (lerr) e.le = 1'b1;
    else if (acc) begin
      e.dest = dest; e.src = src; e.len = (inst == 0) ? {1'b0, len[3:0]} : len; e.pay = '0;
    end
    if (!hdr_only && !lerr) begin
      for (int k = 0; k < nb; k++) begin
        bv = seed + 8'(k * 8'h11);
        e.pay = acc ? {e.pay[119:0], bv} : e.pay;
        for (int i = 7; i >= 0; i--) begin bq.push_back(bv[i]); c = crc_step(c, bv[i]); end
      end
      if (acc) e.fv = ~flip;
      if (acc) e.ce = flip;
      c = c ^ {7'd0, flip};
      for (int i = 7; i >= 0; i--) bq.push_back(c[i]);
    end
    if (abort_at < 0) begin
      if (inst == 0) m0 = e; else m1 = e;
      if (lerr || acc) begin
        if (inst == 0) begin q0.push_back(e); pushed0++; end
        else begin q1.push_back(e); pushed1++; end
      end
    end
    for (int i = 0; i < bq.size(); i++) begin
      if (i == abort_at) return;
      if (inst == 0) rx0 = bq[i]; else rx1 = bq[i];
      @(posedge clk); #1;
      if (i == 23) begin
        if (inst == 0) chkv("u0 flags clear at SFD", {28'd0, d0_fv, d0_ce, d0_le, d0_busy}, 32'h1);
        else           chkv("u1 flags clear at SFD", {28'd0, d1_fv, d1_ce, d1_le, d1_busy}, 32'h1);
      end
    end
    rx0 = 1'b0; rx1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx0 = 1'b0; rx1 = 1'b0;
    m0 = '0; m1 = '0;
    #12;
    chkv("u0 reset outputs", {26'd0, d0_fv, d0_ce, d0_le, d0_fd, d0_busy, |{d0_dest, d0_src, d0_len, d0_pay}}, 32'd0);
    chkv("u1 reset outputs", {26'd0, d1_fv, d1_ce, d1_le, d1_fd, d1_busy, |{d1_dest, d1_src, d1_len, d1_pay}}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    idle(3);

    // Basic good frame
    send_frame(0, 2'd0, 2'd0, 5'd3, 8'h11, 1'b0, 1'b0, -1);
    idle(4);
    chkv("t1 payload", d0_pay[31:0], 32'h11223344);
    chkv("t1 valid/len", {27'd0, d0_fv, d0_len}, {27'd0, 1'b1, 4'd3});

    // CRC byte bit0 flipped
    send_frame(0, 2'd0, 2'd0, 5'd3, 8'h11, 1'b1, 1'b0, -1);
    idle(4);
    chkv("t2 payload", d0_pay[31:0], 32'h11223344);
    chkv("t2 flags", {30'd0, d0_fv, d0_ce}, 32'h1);

    // Address mismatch dropped, broadcast accepted
    send_frame(0, 2'd2, 2'd1, 5'd1, 8'h05, 1'b0, 1'b0, -1);
    idle(4);
    chkv("t3 drop keeps data", {d0_pay[23:0], d0_dest, d0_len, d0_busy, 1'b0}, {24'h223344, 2'd0, 4'd3, 1'b0, 1'b0});
    send_frame(0, 2'd3, 2'd2, 5'd0, 8'h5A, 1'b0, 1'b0, -1);
    idle(4);
    chkv("t3 bcast dest", {30'd0, d0_dest}, 32'd3);

    // Length out of range, then normal frames incl. full 16-byte payload
    send_frame(1, 2'd0, 2'd1, 5'd16, 8'h00, 1'b0, 1'b1, -1);
    idle(4);
    chkv("t4 len_error", {30'd0, d1_le, d1_busy}, 32'h2);
    send_frame(1, 2'd0, 2'd1, 5'd4, 8'h21, 1'b0, 1'b0, -1);
    idle(4);
    send_frame(1, 2'd3, 2'd0, 5'd15, 8'h01, 1'b0, 1'b0, -1);
    idle(4);

    // Reset mid-payload
    send_frame(0, 2'd0, 2'd1, 5'd7, 8'h10, 1'b0, 1'b0, 24 + 8 + 20);
    #2 rst = 1'b1;
    #1;
    chkv("t5 async reset", {25'd0, d0_fv, d0_ce, d0_le, d0_fd, d0_busy, |{d0_dest, d0_src, d0_len}, |d0_pay}, 32'd0);
    m0 = '0; m1 = '0;
    #3 rst = 1'b0;
    idle(3);
    send_frame(0, 2'd0, 2'd2, 5'd2, 8'h33, 1'b0, 1'b0, -1);
    idle(4);

    // Back-to-back frames with no idle bits
    send_frame(0, 2'd0, 2'd0, 5'd5, 8'h40, 1'b1, 1'b0, -1);
    send_frame(0, 2'd3, 2'd1, 5'd1, 8'h77, 1'b0, 1'b0, -1);
    idle(6);

    chkv("u0 done count", 32'(seen0), 32'(pushed0));
    chkv("u1 done count", 32'(seen1), 32'(pushed1));
    chkv("idle busy", {30'd0, d0_busy, d1_busy}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
